// File: rtl/traffic_phase_arbiter.sv
// Intersection phase controller: shares green between N/S, E/W and a
// pedestrian walk phase, with min/max green, yellow and all-red timing.
module traffic_phase_arbiter #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int WALK      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    output logic [2:0] light_N,
    output logic [2:0] light_S,
    output logic [2:0] light_E,
    output logic [2:0] light_W,
    output logic       ped_walk,
    output logic [2:0] phase
);

    localparam int PW   = $clog2(CLK_DIV);
    localparam int M1   = (MAX_GREEN > WALK) ? MAX_GREEN : WALK;
    localparam int M2   = (ALL_RED > YELLOW) ? ALL_RED : YELLOW;
    localparam int TMAX = (M1 > M2) ? M1 : M2;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] MIN_T    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_T    = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_T    = TW'(YELLOW - 1);
    localparam logic [TW-1:0] RED_T    = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] WALK_T   = TW'(WALK - 1);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_NS_G   = 3'd1,
        S_NS_Y   = 3'd2,
        S_EW_G   = 3'd3,
        S_EW_Y   = 3'd4,
        S_WALK   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   t_q, t_d;
    logic            ped_pending_q, ped_pending_d;
    logic            next_dir_q, next_dir_d;
    logic            tick;
    logic            ns_go;
    logic            ew_go;
    logic            green;
    logic            changing;

    assign tick  = (presc_q == PRE_LAST);
    assign green = (state_q == S_NS_G) || (state_q == S_EW_G);

    // Leave green only when someone else is waiting: gap-out or max-out.
    assign ns_go = (req_ew || ped_pending_q) &&
                   (((t_q >= MIN_T) && !req_ns) || (t_q >= MAX_T));
    assign ew_go = (req_ns || ped_pending_q) &&
                   (((t_q >= MIN_T) && !req_ew) || (t_q >= MAX_T));

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_ALLRED: if (t_q == RED_T)
                    state_d = ped_pending_q ? S_WALK :
                              (next_dir_q ? S_EW_G : S_NS_G);
                S_NS_G: if (ns_go) state_d = S_NS_Y;
                S_NS_Y: if (t_q == YEL_T) state_d = S_ALLRED;
                S_EW_G: if (ew_go) state_d = S_EW_Y;
                S_EW_Y: if (t_q == YEL_T) state_d = S_ALLRED;
                S_WALK: if (t_q == WALK_T)
                    state_d = next_dir_q ? S_EW_G : S_NS_G;
                default: state_d = S_ALLRED;
            endcase
        end
    end

    assign changing = (state_d != state_q);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;

        t_d = t_q;
        if (changing)
            t_d = '0;
        else if (tick && !(green && (t_q == MAX_T)))
            t_d = t_q + 1'b1;

        // Entry to WALK wins over a same-cycle button press.
        ped_pending_d = ped_pending_q;
        if (changing && (state_d == S_WALK))
            ped_pending_d = 1'b0;
        else if (ped_req && (state_q != S_WALK))
            ped_pending_d = 1'b1;

        next_dir_d = next_dir_q;
        if (changing && (state_d == S_NS_Y))
            next_dir_d = 1'b1;
        else if (changing && (state_d == S_EW_Y))
            next_dir_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ALLRED;
            presc_q       <= '0;
            t_q           <= '0;
            ped_pending_q <= 1'b0;
            next_dir_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            t_q           <= t_d;
            ped_pending_q <= ped_pending_d;
            next_dir_q    <= next_dir_d;
        end
    end

    always_comb begin
        light_N  = L_RED;
        light_S  = L_RED;
        light_E  = L_RED;
        light_W  = L_RED;
        ped_walk = 1'b0;
        case (state_q)
            S_NS_G: begin
                light_N = L_GRN;
                light_S = L_GRN;
            end
            S_NS_Y: begin
                light_N = L_YEL;
                light_S = L_YEL;
            end
            S_EW_G: begin
                light_E = L_GRN;
                light_W = L_GRN;
            end
            S_EW_Y: begin
                light_E = L_YEL;
                light_W = L_YEL;
            end
            S_WALK:  ped_walk = 1'b1;
            default: ped_walk = 1'b0;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Scoreboard bench for traffic_phase_arbiter: expected phases are queued
// per clock as stimulus advances and compared on the following falling edge.
module tb_traffic_phase_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_ns;
    logic       req_ew;
    logic       ped_req;
    logic [2:0] light_N;
    logic [2:0] light_S;
    logic [2:0] light_E;
    logic [2:0] light_W;
    logic       ped_walk;
    logic [2:0] phase;

    int n_chk;
    int n_err;

    logic [2:0] exp_q[$];
    logic [2:0] mon_ph;

    traffic_phase_arbiter #(
        .CLK_DIV  (4),
        .MIN_GREEN(2),
        .MAX_GREEN(4),
        .YELLOW   (1),
        .ALL_RED  (1),
        .WALK     (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_ns  (req_ns),
        .req_ew  (req_ew),
        .ped_req (ped_req),
        .light_N (light_N),
        .light_S (light_S),
        .light_E (light_E),
        .light_W (light_W),
        .ped_walk(ped_walk),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    // {N,S,E,W,walk} for each phase code
    function automatic logic [12:0] lamps_of(input logic [2:0] ph);
        case (ph)
            3'd1:    return {3'b001, 3'b001, 3'b100, 3'b100, 1'b0};
            3'd2:    return {3'b010, 3'b010, 3'b100, 3'b100, 1'b0};
            3'd3:    return {3'b100, 3'b100, 3'b001, 3'b001, 1'b0};
            3'd4:    return {3'b100, 3'b100, 3'b010, 3'b010, 1'b0};
            3'd5:    return {3'b100, 3'b100, 3'b100, 3'b100, 1'b1};
            default: return {3'b100, 3'b100, 3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_ph = exp_q.pop_front();
            chk("phase", {13'd0, phase}, {13'd0, mon_ph});
            chk("lamps",
                {3'd0, light_N, light_S, light_E, light_W, ped_walk},
                {3'd0, lamps_of(mon_ph)});
        end
    end

    task automatic step_exp(input logic [2:0] ph, input int n);
        repeat (n) begin
            @(posedge clk);
            exp_q.push_back(ph);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        req_ns  = 1'b0;
        req_ew  = 1'b0;
        ped_req = 1'b0;
        step_exp(3'd0, n);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        req_ns  = 1'b0;
        req_ew  = 1'b0;
        ped_req = 1'b0;

        // power-on reset, then idle rest in NS green
        step_exp(3'd0, 100);
        #1 rst_n = 1'b1;
        step_exp(3'd0, 3);
        step_exp(3'd1, 200);

        // E/W demand only: gap-out after min green
        do_reset(3);
        req_ew = 1'b1;
        step_exp(3'd0, 3);
        step_exp(3'd1, 8);
        step_exp(3'd2, 4);
        step_exp(3'd0, 4);
        step_exp(3'd3, 20);

        // both demands held: max-out alternation
        do_reset(3);
        req_ns = 1'b1;
        req_ew = 1'b1;
        step_exp(3'd0, 3);
        step_exp(3'd1, 16);
        step_exp(3'd2, 4);
        step_exp(3'd0, 4);
        step_exp(3'd3, 16);
        step_exp(3'd4, 4);
        step_exp(3'd0, 4);
        step_exp(3'd1, 16);
        step_exp(3'd2, 4);
        step_exp(3'd0, 4);
        step_exp(3'd3, 5);

        // pedestrian pulse in NS green; second pulse during WALK ignored
        do_reset(3);
        step_exp(3'd0, 3);
        step_exp(3'd1, 1);
        #1 ped_req = 1'b1;
        step_exp(3'd1, 1);
        #1 ped_req = 1'b0;
        step_exp(3'd1, 6);
        step_exp(3'd2, 4);
        step_exp(3'd0, 4);
        step_exp(3'd5, 2);
        #1 ped_req = 1'b1;
        step_exp(3'd5, 1);
        #1 ped_req = 1'b0;
        step_exp(3'd5, 5);
        step_exp(3'd3, 30);

        // asynchronous reset in the middle of EW yellow
        do_reset(3);
        req_ns = 1'b1;
        req_ew = 1'b1;
        step_exp(3'd0, 3);
        step_exp(3'd1, 16);
        step_exp(3'd2, 4);
        step_exp(3'd0, 4);
        step_exp(3'd3, 16);
        step_exp(3'd4, 2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_phase", {13'd0, phase}, 16'd0);
        chk("async_lamps",
            {3'd0, light_N, light_S, light_E, light_W, ped_walk},
            {3'd0, lamps_of(3'd0)});
        req_ns = 1'b0;
        req_ew = 1'b0;
        step_exp(3'd0, 5);
        #1 rst_n = 1'b1;
        step_exp(3'd0, 3);
        step_exp(3'd1, 10);

        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
